sdram_ring_writer: RTL and testbench
====================================

// Module: sdram_ring_writer
// PURPOSE
//  Multi-channel periodic sampler that streams NUM_CH words per tick into an SDRAM ring buffer over an Avalon-MM write master.
//  Successor to the single-channel fixed-interval SDRAM writer: obeys waitrequest, buffers sample sets, counts overruns, reports the ring end offset on interrupt.
//  Sits between the acquisition front-end and the HPS SDRAM bridge.
// PARAMETERS
//  NUM_CH        4      channels per sample set (1..16)
//  DATA_W        32     bits per channel sample
//  BUS_W         64     Avalon writedata width (>= DATA_W)
//  CNT_INTERVAL  223    clk cycles between ticks (>= NUM_CH+2)
//  RBUF_ENTRIES  10000  sample sets held in the ring
//  ADDR_STEP     2      address increment per written word
//  FIFO_DEPTH    4      sample sets buffered, including the set in flight (power of 2, >= 2)
// PORTS
//  clk          in   1              system clock
//  reset_n      in   1              asynchronous, active-low reset
//  enable       in   1              1 = tick counter runs
//  data         in   NUM_CH*DATA_W  channel samples; ch0 in LSBs
//  mem_addr     in   32             ring base address
//  interrupt_id in   8              nonzero = latch end_address
//  address      out  32             Avalon address
//  write        out  1              Avalon write
//  writedata    out  BUS_W          Avalon writedata
//  waitrequest  in   1              Avalon waitrequest
//  end_address  out  32             ring offset of next set to write
//  overrun_cnt  out  16             dropped sets (saturating)
//  wrapped      out  1              1-cycle pulse when ring index wraps
// BEHAVIOUR
//  Reset (async, all state): address=0, write=0, writedata=0, end_address=0, overrun_cnt=0, wrapped=0; FIFO empty; idx=0; cnt=0; FSM IDLE.
//   Reset mid-transfer abandons the word in flight.
//  Tick: cnt counts 0..CNT_INTERVAL-1 while enable=1 and holds at 0 while enable=0. Tick = (cnt==CNT_INTERVAL-1).
//   Disabling does not stop draining of sets already buffered.
//  On a tick edge, data is pushed into the FIFO as one set.
//   If the FIFO is full, the set is dropped and overrun_cnt increments, saturating at 16'hFFFF.
//  FSM states IDLE and BURST.
//   IDLE with FIFO non-empty: at the next edge, latch base=mem_addr and drive ch0 (write=1), then go to BURST.
//   Write latency is 1 cycle after the tick edge when the FIFO was empty.
//  BURST: a word is accepted on an edge with write=1 and waitrequest=0.
//   While waitrequest=1, address, write and writedata hold stable.
//   Word ch is driven at address = base + (idx*NUM_CH + ch)*ADDR_STEP.
//   writedata = zero-extended sample ch.
//   On the edge the last channel is accepted:
//    - pop the FIFO;
//    - idx <= (idx==RBUF_ENTRIES-1) ? 0 : idx+1, with wrapped=1 on the wrap;
//    - if the FIFO is still non-empty, drive the next set's ch0 on that same edge (back-to-back); otherwise write=0 and go to IDLE.
//  Push and pop on the same edge are both honoured; the full check uses the pre-pop count.
//  end_address: when interrupt_id!=0 at an edge, latch idx*NUM_CH*ADDR_STEP.
//   idx is the post-update value if a set completes on that same edge.
//  Arithmetic is 32-bit unsigned, modulo 2^32.
//  Static elaboration errors for: CNT_INTERVAL<NUM_CH+2, BUS_W<DATA_W, FIFO_DEPTH not a power of 2.
// CONFIGURATION
//  SDRAM_RING_TIMESTAMP_EN defined:
//   writedata[DATA_W+31:DATA_W] = 32-bit sequence number of the set.
//   The sequence number increments per pushed set (dropped sets do not count) and wraps at 2^32.
//   Requires BUS_W >= DATA_W+32; elaboration error otherwise.
//  SDRAM_RING_TIMESTAMP_EN undefined: all bits above DATA_W are 0, and no sequence counter is built.
// STRUCTURE
//  Package sdram_ring_pkg:
//   - state_t enum {IDLE, BURST};
//   - localparam functions for idx, ch and FIFO pointer widths ($clog2);
//   - OVR_MAX constant.
//  Sub-module sdram_ring_fifo:
//   - show-ahead, FIFO_DEPTH x (NUM_CH*DATA_W [+32]);
//   - push, pop, full, empty.
//  Top level holds the tick counter, FSM, address generation and status.
// TESTING
//  1. NUM_CH=1, CNT_INTERVAL=8, waitrequest=0, mem_addr=0x1000, data=0xA5A50001 -> one write every 8 cycles at 0x1000, 0x1002, 0x1004; writedata=0x00000000A5A50001.
//  2. NUM_CH=1, RBUF_ENTRIES=4 -> addresses 0x1000, 0x1002, 0x1004, 0x1006, 0x1000; wrapped pulses once, on the 4th acceptance.
//  3. NUM_CH=4, waitrequest=1 for 3 cycles on word ch1 -> outputs frozen through the stall; addresses base+0, 2, 4, 6 in channel order.
//  4. FIFO_DEPTH=2, waitrequest=1 across 5 ticks -> overrun_cnt=3; after release two sets are written and idx advances by 2.
//  5. NUM_CH=1, ADDR_STEP=2, 3 sets written, then interrupt_id=8'h03 -> end_address=6.
//  6. reset_n low mid-burst -> write=0, address=0, overrun_cnt=0 at once; after release the first write goes to mem_addr+0.
//     With SDRAM_RING_TIMESTAMP_EN defined, upper words carry 0, 1, 2.

Source files
------------

// File: rtl/sdram_ring_pkg.sv
// Shared types and elaboration helpers for the SDRAM ring writer.
//   state_t  : write-master FSM states
//   OVR_MAX  : saturation value of the overrun counter
//   idx_w / ch_w / ptr_w : index widths derived from parameters (min 1 bit)
package sdram_ring_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [15:0] OVR_MAX = 16'hFFFF;

  function automatic int idx_w(input int entries);
    return (entries <= 1) ? 1 : $clog2(entries);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sdram_ring_fifo.sv
// Show-ahead FIFO holding whole sample sets.
//   clk, reset_n : clock, async active-low reset (pointers/count only)
//   i_push/i_wdata : write one entry; ignored when full
//   i_pop          : drop the head entry; ignored when empty
//   o_head         : entry at the read pointer
//   o_next         : entry behind the head (valid when o_count >= 2)
//   o_full/o_empty/o_count : occupancy
module sdram_ring_fifo import sdram_ring_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_head,
  output logic [WIDTH-1:0]        o_next,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ptr_w(DEPTH):0]   o_count
);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_next  = r_mem[r_rptr + 1'b1];
  assign o_count = r_count;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_ring_writer.sv
// Multi-channel periodic sampler writing NUM_CH words per tick into an SDRAM
// ring through an Avalon-MM write master.
//   clk, reset_n        : clock, async active-low reset
//   enable              : tick counter runs while high
//   data                : NUM_CH samples, ch0 in LSBs
//   mem_addr            : ring base address (latched at start of each burst)
//   interrupt_id        : nonzero latches end_address
//   address/write/writedata/waitrequest : Avalon write master
//   end_address         : ring byte offset of the next set to write
//   overrun_cnt         : sets dropped on a full FIFO (saturating)
//   wrapped             : 1-cycle pulse when the ring index wraps
// Optional: define SDRAM_RING_TIMESTAMP_EN to place a 32-bit per-set sequence
// number in writedata[DATA_W+31:DATA_W].
module sdram_ring_writer import sdram_ring_pkg::*; #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 32,
  parameter int BUS_W        = 64,
  parameter int CNT_INTERVAL = 223,
  parameter int RBUF_ENTRIES = 10000,
  parameter int ADDR_STEP    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic [31:0]              mem_addr,
  input  logic [7:0]               interrupt_id,
  output logic [31:0]              address,
  output logic                     write,
  output logic [BUS_W-1:0]         writedata,
  input  logic                     waitrequest,
  output logic [31:0]              end_address,
  output logic [15:0]              overrun_cnt,
  output logic                     wrapped
);
  localparam int SET_W = NUM_CH * DATA_W;
`ifdef SDRAM_RING_TIMESTAMP_EN
  localparam int ENT_W = SET_W + 32;
`else
  localparam int ENT_W = SET_W;
`endif
  localparam int CNT_W = $clog2(CNT_INTERVAL);
  localparam int IDX_W = idx_w(RBUF_ENTRIES);
  localparam int CH_W  = ch_w(NUM_CH);
  localparam int PW    = ptr_w(FIFO_DEPTH);

  if (CNT_INTERVAL < NUM_CH + 2) begin : g_err_interval
    $error("CNT_INTERVAL must be >= NUM_CH+2");
  end
  if (BUS_W < DATA_W) begin : g_err_bus
    $error("BUS_W must be >= DATA_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
`ifdef SDRAM_RING_TIMESTAMP_EN
  if (BUS_W < DATA_W + 32) begin : g_err_ts
    $error("BUS_W must be >= DATA_W+32 with timestamps");
  end
`endif

  // Avalon word: sample ch zero-extended, optional sequence number above it.
  function automatic logic [BUS_W-1:0] mk_word(input logic [ENT_W-1:0] ent, input int ch);
    logic [BUS_W-1:0] w;
    w = '0;
    w[DATA_W-1:0] = ent[ch*DATA_W +: DATA_W];
`ifdef SDRAM_RING_TIMESTAMP_EN
    w[DATA_W +: 32] = ent[SET_W +: 32];
`endif
    return w;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx,
                                            input logic [CH_W-1:0] ch);
    return base + (32'(idx) * 32'(NUM_CH) + 32'(ch)) * 32'(ADDR_STEP);
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [CH_W-1:0]  r_ch;
  logic [31:0]      r_base, r_address, r_end;
  logic [BUS_W-1:0] r_wdata;
  logic [15:0]      r_ovr;
  logic             r_write, r_wrapped;
  state_t           r_state;

  logic             w_tick, w_full, w_empty, w_accept, w_last, w_pop, w_more;
  logic [ENT_W-1:0] w_push_ent, w_head, w_fifo_next, w_next_ent;
  logic [PW:0]      w_count;
  logic [IDX_W-1:0] w_idx_nxt;

  assign w_tick = enable && (r_cnt == CNT_W'(CNT_INTERVAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_cnt <= '0;
    else if (!enable || w_tick)    r_cnt <= '0;
    else                           r_cnt <= r_cnt + 1'b1;
  end

`ifdef SDRAM_RING_TIMESTAMP_EN
  logic [31:0] r_seq;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_seq <= '0;
    else if (w_tick && !w_full) r_seq <= r_seq + 32'd1;
  end
  assign w_push_ent = {r_seq, data};
`else
  assign w_push_ent = data;
`endif

  sdram_ring_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_tick),
    .i_wdata (w_push_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_fifo_next),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_accept  = r_write && !waitrequest;
  assign w_last    = (r_ch == CH_W'(NUM_CH - 1));
  assign w_pop     = w_accept && w_last;
  assign w_idx_nxt = !w_pop ? r_idx :
                     (r_idx == IDX_W'(RBUF_ENTRIES - 1)) ? '0 : r_idx + 1'b1;
  // After popping the head, the next set is either the second stored entry
  // or, if the head was the only one, the set being pushed on this same edge
  // (a push into a 1-entry FIFO is never dropped since depth >= 2).
  assign w_more     = (w_count > (PW+1)'(1)) || w_tick;
  assign w_next_ent = (w_count > (PW+1)'(1)) ? w_fifo_next : w_push_ent;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_ch      <= '0;
      r_base    <= '0;
      r_address <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_end     <= '0;
      r_ovr     <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_wrapped <= 1'b0;
      if (interrupt_id != 8'h00)
        r_end <= 32'(w_idx_nxt) * 32'(NUM_CH) * 32'(ADDR_STEP);
      if (w_tick && w_full && r_ovr != OVR_MAX)
        r_ovr <= r_ovr + 16'd1;
      case (r_state)
        IDLE: if (!w_empty) begin
          r_base    <= mem_addr;
          r_ch      <= '0;
          r_address <= word_addr(mem_addr, r_idx, '0);
          r_wdata   <= mk_word(w_head, 0);
          r_write   <= 1'b1;
          r_state   <= BURST;
        end
        BURST: if (w_accept) begin
          if (w_last) begin
            r_idx <= w_idx_nxt;
            if (r_idx == IDX_W'(RBUF_ENTRIES - 1)) r_wrapped <= 1'b1;
            if (w_more) begin
              r_ch      <= '0;
              r_address <= word_addr(r_base, w_idx_nxt, '0);
              r_wdata   <= mk_word(w_next_ent, 0);
            end else begin
              r_write <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_ch      <= r_ch + 1'b1;
            r_address <= word_addr(r_base, r_idx, CH_W'(r_ch + 1'b1));
            r_wdata   <= mk_word(w_head, int'(r_ch) + 1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign address     = r_address;
  assign write       = r_write;
  assign writedata   = r_wdata;
  assign end_address = r_end;
  assign overrun_cnt = r_ovr;
  assign wrapped     = r_wrapped;

endmodule

// File: tb/tb_sdram_ring_writer.sv
`timescale 1ns/1ps
module tb_sdram_ring_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  int checks = 0, errors = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  typedef struct packed { logic [31:0] addr; logic [63:0] data; } exp_t;
  exp_t qa[$], qb[$];
  int   a_times[$], b_times[$];
  int   a_wraps, a_wrap_at, b_stall_ch1;
  bit   b_prev_stall;
  logic [31:0] b_paddr;
  logic [63:0] b_pdata;

  // DUT A: single channel, small ring, 2-deep FIFO
  logic        a_en = 0, a_wait = 0, a_wr, a_wrap;
  logic [31:0] a_data = 0, a_base = 0, a_addr, a_end;
  logic [7:0]  a_irq = 0;
  logic [63:0] a_wd;
  logic [15:0] a_ovr;

  sdram_ring_writer #(.NUM_CH(1), .DATA_W(32), .BUS_W(64), .CNT_INTERVAL(8),
                      .RBUF_ENTRIES(4), .ADDR_STEP(2), .FIFO_DEPTH(2)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(a_en), .data(a_data), .mem_addr(a_base),
    .interrupt_id(a_irq), .address(a_addr), .write(a_wr), .writedata(a_wd),
    .waitrequest(a_wait), .end_address(a_end), .overrun_cnt(a_ovr), .wrapped(a_wrap));

  // DUT B: four channels, large ring, 4-deep FIFO
  logic         b_en = 0, b_wait = 0, b_wr, b_wrap;
  logic [127:0] b_data = 0;
  logic [31:0]  b_base = 0, b_addr, b_end;
  logic [7:0]   b_irq = 0;
  logic [63:0]  b_wd;
  logic [15:0]  b_ovr;

  sdram_ring_writer #(.NUM_CH(4), .DATA_W(32), .BUS_W(64), .CNT_INTERVAL(8),
                      .RBUF_ENTRIES(10000), .ADDR_STEP(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(b_en), .data(b_data), .mem_addr(b_base),
    .interrupt_id(b_irq), .address(b_addr), .write(b_wr), .writedata(b_wd),
    .waitrequest(b_wait), .end_address(b_end), .overrun_cnt(b_ovr), .wrapped(b_wrap));

  function automatic logic [63:0] expw(input logic [31:0] s, input logic [31:0] seq);
`ifdef SDRAM_RING_TIMESTAMP_EN
    return {seq, s};
`else
    return {32'h0, s};
`endif
  endfunction

  function automatic logic [31:0] bch(input int s, input int ch);
    return 32'hA000_0000 + 32'(ch) * 32'h0100_0000 + 32'(s);
  endfunction

  function automatic logic [127:0] bset(input int s);
    logic [127:0] v;
    for (int c = 0; c < 4; c++) v[c*32 +: 32] = bch(s, c);
    return v;
  endfunction

  // Monitors: sample at negedge; a word seen with write=1, waitrequest=0 is
  // accepted on the following posedge.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (a_wrap) begin a_wraps++; a_wrap_at = a_times.size(); end
      if (a_wr && !a_wait) begin
        exp_t e;
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL a_write: unexpected addr=%h data=%h, none required", a_addr, a_wd);
        end else begin
          e = qa.pop_front();
          if (a_addr !== e.addr || a_wd !== e.data) begin
            errors++;
            $display("FAIL a_write: got addr=%h data=%h, required addr=%h data=%h", a_addr, a_wd, e.addr, e.data);
          end
        end
        a_times.push_back(cyc);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (b_prev_stall) begin
        checks++;
        if (b_wr !== 1'b1 || b_addr !== b_paddr || b_wd !== b_pdata) begin
          errors++;
          $display("FAIL b_stall_hold: got wr=%b addr=%h data=%h, required wr=1 addr=%h data=%h", b_wr, b_addr, b_wd, b_paddr, b_pdata);
        end
      end
      b_prev_stall = b_wr && b_wait;
      b_paddr = b_addr;
      b_pdata = b_wd;
      if (b_wr && b_wait && b_addr == 32'h2002) b_stall_ch1++;
      if (b_wr && !b_wait) begin
        exp_t e;
        checks++;
        if (qb.size() == 0) begin
          errors++; $display("FAIL b_write: unexpected addr=%h data=%h, none required", b_addr, b_wd);
        end else begin
          e = qb.pop_front();
          if (b_addr !== e.addr || b_wd !== e.data) begin
            errors++;
            $display("FAIL b_write: got addr=%h data=%h, required addr=%h data=%h", b_addr, b_wd, e.addr, e.data);
          end
        end
        b_times.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    a_en = 0; b_en = 0; a_wait = 0; b_wait = 0; a_irq = 0; b_irq = 0;
    qa.delete(); qb.delete(); a_times.delete(); b_times.delete();
    a_wraps = 0; a_wrap_at = -1; b_stall_ch1 = 0; b_prev_stall = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_a(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (a_times.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_b(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (b_times.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_addr, a_wr, a_wd, a_end, a_ovr, a_wrap} !== '0) begin
      errors++; $display("FAIL reset_a: got addr=%h wr=%b wd=%h end=%h ovr=%h wrap=%b, required all 0", a_addr, a_wr, a_wd, a_end, a_ovr, a_wrap);
    end
    checks++;
    if ({b_addr, b_wr, b_wd, b_end, b_ovr, b_wrap} !== '0) begin
      errors++; $display("FAIL reset_b: got addr=%h wr=%b wd=%h end=%h ovr=%h wrap=%b, required all 0", b_addr, b_wr, b_wd, b_end, b_ovr, b_wrap);
    end
  endtask

  task automatic test_stream_wrap();
    int t0; bit ok;
    do_reset();
    a_base = 32'h1000; a_data = 32'hA5A50001;
    for (int i = 0; i < 5; i++) qa.push_back('{32'h1000 + 32'(2 * (i % 4)), expw(32'hA5A50001, 32'(i))});
    @(posedge clk); #1 a_en = 1; t0 = cyc;
    wait_a(5, 60, ok);
    a_en = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_timeout: got %0d writes, required 5", a_times.size()); end
    else begin
      checks++;
      if (a_times[0] - t0 !== 9) begin errors++; $display("FAIL first_latency: got %0d, required 9", a_times[0] - t0); end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (a_times[i] - a_times[i-1] !== 8) begin
          errors++; $display("FAIL tick_spacing[%0d]: got %0d, required 8", i, a_times[i] - a_times[i-1]);
        end
      end
    end
    repeat (12) @(posedge clk); #1;
    checks++;
    if (a_wraps !== 1 || a_wrap_at !== 4) begin
      errors++; $display("FAIL wrap_pulse: got %0d pulses after write %0d, required 1 after write 4", a_wraps, a_wrap_at);
    end
    checks++;
    if (qa.size() !== 0) begin errors++; $display("FAIL stream_left: got %0d pending, required 0", qa.size()); end
  endtask

  task automatic test_end_address();
    bit ok;
    do_reset();
    a_base = 32'h1000;
    for (int i = 0; i < 3; i++) qa.push_back('{32'h1000 + 32'(2 * i), expw(32'h7700 + 32'(i), 32'(i))});
    a_data = 32'h7700;
    @(posedge clk); #1 a_en = 1;
    for (int i = 0; i < 3; i++) begin
      wait_a(i + 1, 30, ok);
      a_data = 32'h7700 + 32'(i + 1);
    end
    a_en = 0;
    checks++;
    if (!ok || a_end !== 32'h0) begin errors++; $display("FAIL end_before_irq: got ok=%0d end=%h, required ok=1 end=0", ok, a_end); end
    a_irq = 8'h03;
    @(posedge clk); #1 a_irq = 8'h00;
    checks++;
    if (a_end !== 32'd6) begin errors++; $display("FAIL end_address: got %0d, required 6", a_end); end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    a_wait = 1; a_base = 32'h1000; a_data = 32'd1;
    @(posedge clk); #1 a_en = 1;
    for (int k = 1; k <= 5; k++) begin
      repeat (8) @(posedge clk); #1;
      a_data = 32'(k + 1);
    end
    a_en = 0;
    checks++;
    if (a_ovr !== 16'd3) begin errors++; $display("FAIL overrun_cnt: got %0d, required 3", a_ovr); end
    checks++;
    if (a_wr !== 1'b1 || a_addr !== 32'h1000) begin errors++; $display("FAIL overrun_stall: got wr=%b addr=%h, required wr=1 addr=1000", a_wr, a_addr); end
    qa.push_back('{32'h1000, expw(32'd1, 32'd0)});
    qa.push_back('{32'h1002, expw(32'd2, 32'd1)});
    a_wait = 0;
    wait_a(2, 20, ok);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (!ok || a_times.size() !== 2) begin errors++; $display("FAIL overrun_drain: got %0d writes, required 2", a_times.size()); end
    a_irq = 8'h01;
    @(posedge clk); #1 a_irq = 8'h00;
    checks++;
    if (a_end !== 32'd4) begin errors++; $display("FAIL overrun_idx: got end=%0d, required 4", a_end); end
  endtask

  task automatic test_stall();
    bit ok, found;
    do_reset();
    b_base = 32'h2000; b_data = bset(0);
    for (int c = 0; c < 4; c++) qb.push_back('{32'h2000 + 32'(2 * c), expw(bch(0, c), 32'd0)});
    @(posedge clk); #1 b_en = 1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b_wr && b_addr == 32'h2002) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_reach_ch1: got no ch1 word, required one"); end
    b_wait = 1; b_en = 0;
    repeat (3) @(posedge clk); #1 b_wait = 0;
    wait_b(4, 20, ok);
    checks++;
    if (!ok || b_stall_ch1 !== 3) begin errors++; $display("FAIL stall_cycles: got ok=%0d stall=%0d, required ok=1 stall=3", ok, b_stall_ch1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    b_wait = 1; b_base = 32'h2000; b_data = bset(0);
    @(posedge clk); #1 b_en = 1;
    for (int k = 0; k < 3; k++) begin
      repeat (8) @(posedge clk); #1;
      b_data = bset(k + 1);
    end
    b_en = 0;
    checks++;
    if (b_ovr !== 16'd0) begin errors++; $display("FAIL b2b_overrun: got %0d, required 0", b_ovr); end
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 4; c++)
        qb.push_back('{32'h2000 + 32'(2 * (4 * s + c)), expw(bch(s, c), 32'(s))});
    b_wait = 0;
    wait_b(12, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d words, required 12", b_times.size()); end
    else begin
      checks++;
      if (b_times[11] - b_times[0] !== 11) begin errors++; $display("FAIL b2b_gapless: got span %0d, required 11", b_times[11] - b_times[0]); end
    end
    b_irq = 8'h80;
    @(posedge clk); #1 b_irq = 8'h00;
    checks++;
    if (b_end !== 32'd24) begin errors++; $display("FAIL b2b_end: got %0d, required 24", b_end); end
  endtask

  task automatic test_reset_midburst();
    bit ok;
    do_reset();
    a_wait = 1; a_base = 32'h1000; a_data = 32'h11;
    @(posedge clk); #1 a_en = 1;
    repeat (32) @(posedge clk); #1;
    checks++;
    if (a_wr !== 1'b1 || a_ovr !== 16'd2) begin errors++; $display("FAIL midburst_pre: got wr=%b ovr=%0d, required wr=1 ovr=2", a_wr, a_ovr); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_wr !== 1'b0 || a_addr !== 32'h0 || a_ovr !== 16'h0) begin
      errors++; $display("FAIL async_reset: got wr=%b addr=%h ovr=%0d, required 0", a_wr, a_addr, a_ovr);
    end
    do_reset();
    a_base = 32'h3000; a_data = 32'h5A00_0000;
    for (int i = 0; i < 3; i++) qa.push_back('{32'h3000 + 32'(2 * i), expw(32'h5A00_0000 + 32'(i), 32'(i))});
    @(posedge clk); #1 a_en = 1;
    for (int i = 0; i < 3; i++) begin
      wait_a(i + 1, 30, ok);
      a_data = 32'h5A00_0000 + 32'(i + 1);
    end
    a_en = 0;
    repeat (4) @(posedge clk); #1;
    checks++;
    if (!ok || qa.size() !== 0) begin errors++; $display("FAIL post_reset_writes: got ok=%0d pending=%0d, required ok=1 pending=0", ok, qa.size()); end
  endtask

  initial begin
    test_reset();
    test_stream_wrap();
    test_end_address();
    test_overrun();
    test_stall();
    test_back_to_back();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
